// File: rtl/jar_ctrl_pkg.sv
// jar_ctrl_pkg: shared types and defaults for the JARchitecture run-control
// logic (Start/Ack responder and its helpers).
//   ctrl_state_t : run-control FSM state encoding
//   PC_W_DEF     : default program counter width
//   CNT_W_DEF    : default run-cycle counter width
package jar_ctrl_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/start_edge_det.sv
// start_edge_det: rising-edge detector for the host Start level.
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   start in  Start level from host
//   rise  out one-cycle pulse: start & ~start_prev
// start_prev resets to 0, so a Start already high when reset releases is
// seen as a rise on the first edge.
module start_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic rise
);

  logic start_prev_d, start_prev_q;

  always_comb begin
    start_prev_d = start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_prev_q <= 1'b0;
    else        start_prev_q <= start_prev_d;
  end

  assign rise = start & ~start_prev_q;

endmodule

// File: rtl/start_ack_ctrl.sv
// start_ack_ctrl: responder side of the Start/Ack run handshake for the
// JARchitecture core. A Start rise loads the PC (PcInit), the core then
// advances (RunEn) until the decoder flags a halt, after which Ack is held
// until the next Start rise. A saturating counter records RUN cycles.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   Start      in   run request level from host
//   Halt       in   current instruction is the halt opcode
//   Ack        out  run finished
//   RunEn      out  core advance enable
//   PcInit     out  one-cycle PC load pulse
//   StartPc    out  constant START_PC
//   CycleCount out  RUN cycles of the current or last run
//   Timeout    out  last run ended by the watchdog
//
// Build option: define START_ACK_WATCHDOG_EN to stop a run that reaches
// WDOG_LIMIT RUN cycles without a halt. Without it Timeout is constant 0.
import jar_ctrl_pkg::*;

module start_ack_ctrl #(
  parameter int              PC_W       = PC_W_DEF,
  parameter logic [PC_W-1:0] START_PC   = '0,
  parameter int              CNT_W      = CNT_W_DEF,
  parameter int unsigned     WDOG_LIMIT = 65535
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  output logic             Ack,
  output logic             RunEn,
  output logic             PcInit,
  output logic [PC_W-1:0]  StartPc,
  output logic [CNT_W-1:0] CycleCount,
  output logic             Timeout
);

`ifdef START_ACK_WATCHDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] WDOG_CNT = CNT_W'(WDOG_LIMIT);

  logic             start_rise;
  ctrl_state_t      state_d, state_q;
  logic [CNT_W-1:0] cycle_count_d, cycle_count_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_d, timeout_q;
  logic             ack_d, ack_q;
  logic             run_en_d, run_en_q;
  logic             pc_init_d, pc_init_q;
  logic             wdog_stop;

  start_edge_det u_edge (
    .clk   (Clk),
    .rst_n (Reset),
    .start (Start),
    .rise  (start_rise)
  );

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (cycle_count_q == CNT_MAX) ? cycle_count_q
                                              : cycle_count_q + CNT_W'(1);

  // Watchdog only fires when no halt is present; halt takes priority.
  // With the feature compiled out WDOG_ON folds this to 0.
  assign wdog_stop = WDOG_ON && (cycle_count_q == WDOG_CNT) && !Halt;

  always_comb begin
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    case (state_q)
      IDLE: if (start_rise) state_d = INIT;
      INIT: state_d = RUN;  // Halt deliberately ignored here
      RUN: begin
        // Start rises in RUN are dropped; Halt wins over a simultaneous rise.
        if (Halt) begin
          state_d       = DONE;
          cycle_count_d = cnt_inc;  // the halting edge still counts
        end else if (wdog_stop) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          cycle_count_d = cnt_inc;
        end
      end
      DONE:    if (start_rise) state_d = INIT;
      default: state_d = IDLE;
    endcase

    // Clear run statistics on entry to INIT so they read 0 during INIT.
    if (state_d == INIT) begin
      cycle_count_d = '0;
      timeout_d     = 1'b0;
    end

    // Moore outputs registered alongside the state they decode.
    ack_d     = (state_d == DONE);
    run_en_d  = (state_d == RUN);
    pc_init_d = (state_d == INIT);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
      ack_q         <= 1'b0;
      run_en_q      <= 1'b0;
      pc_init_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      ack_q         <= ack_d;
      run_en_q      <= run_en_d;
      pc_init_q     <= pc_init_d;
    end
  end

  assign Ack        = ack_q;
  assign RunEn      = run_en_q;
  assign PcInit     = pc_init_q;
  assign StartPc    = START_PC;
  assign CycleCount = cycle_count_q;
  assign Timeout    = timeout_q;  // constant 0 unless the watchdog is built in

endmodule

// File: tb/tb_start_ack_ctrl.sv
// tb_start_ack_ctrl: scoreboard bench for start_ack_ctrl. Each run pushes
// its expected {CycleCount, Timeout}; the monitor pops and compares when
// Ack rises. Small CNT_W keeps the saturation case short.
module tb_start_ack_ctrl;

  localparam int              PC_W     = 10;
  localparam logic [PC_W-1:0] START_PC = 10'h2A5;
  localparam int              CNT_W    = 6;
  localparam int              WDOG     = 8;

  logic             Clk, Reset, Start, Halt;
  logic             Ack, RunEn, PcInit, Timeout;
  logic [PC_W-1:0]  StartPc;
  logic [CNT_W-1:0] CycleCount;

  typedef struct packed {
    logic [31:0] cnt;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   pc_cnt = 0;
  int   run_cnt = 0;
  logic ack_prev = 1'b0;

  start_ack_ctrl #(
    .PC_W(PC_W), .START_PC(START_PC), .CNT_W(CNT_W), .WDOG_LIMIT(WDOG)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
    .Ack(Ack), .RunEn(RunEn), .PcInit(PcInit), .StartPc(StartPc),
    .CycleCount(CycleCount), .Timeout(Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input int cnt, input logic to);
    exp_t e;
    e.cnt = cnt;
    e.to  = to;
    sb.push_back(e);
  endtask

  // Single-cycle Start pulse; returns with the DUT in its first RUN cycle.
  task automatic launch();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
  endtask

  // Halt sampled on the n-th RUN edge.
  task automatic halt_after(input int n);
    push(n, 1'b0);
    repeat (n - 1) tick();
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
  endtask

  // Monitor: pulse counters and scoreboard pop on Ack rise.
  always @(negedge Clk) begin
    if (PcInit) pc_cnt <= pc_cnt + 1;
    if (RunEn)  run_cnt <= run_cnt + 1;
    if (Ack && !ack_prev) begin
      if (sb.size() == 0) chk("sb_unexpected_ack", 32'd1, 32'd0);
      else begin
        chk("sb_count", 32'(CycleCount), sb[0].cnt);
        chk("sb_timeout", 32'(Timeout), 32'(sb[0].to));
        void'(sb.pop_front());
      end
    end
    ack_prev <= Ack;
  end

  initial begin
    int p0, r0;
    Reset = 1'b0; Start = 1'b0; Halt = 1'b0;
    #1;
    chk("rst_ack", 32'(Ack), 0);
    chk("rst_runen", 32'(RunEn), 0);
    chk("rst_pcinit", 32'(PcInit), 0);
    chk("rst_count", 32'(CycleCount), 0);
    chk("rst_timeout", 32'(Timeout), 0);
    chk("startpc", 32'(StartPc), 32'(START_PC));
    repeat (2) tick();
    Reset = 1'b1;
    tick();

    // 1: basic pulse, halt after 5 RUN cycles
    p0 = pc_cnt; r0 = run_cnt;
    launch();
    chk("t1_runen", 32'(RunEn), 1);
    halt_after(5);
    chk("t1_ack", 32'(Ack), 1);
    chk("t1_runen_off", 32'(RunEn), 0);
    tick();
    chk("t1_pcinit_cycles", 32'(pc_cnt - p0), 1);
    chk("t1_runen_cycles", 32'(run_cnt - r0), 5);

    // 2: Start held 20 cycles -> one run only
    p0 = pc_cnt;
    Start = 1'b1;
    tick(); tick();
    halt_after(3);
    repeat (15) tick();
    chk("t2_ack_held", 32'(Ack), 1);
    chk("t2_one_init", 32'(pc_cnt - p0), 1);
    chk("t2_runen", 32'(RunEn), 0);
    Start = 1'b0;
    tick();

    // 3: restart from DONE
    Start = 1'b1;
    tick();
    chk("t3_ack_fall", 32'(Ack), 0);
    chk("t3_count_clr", 32'(CycleCount), 0);
    chk("t3_pcinit", 32'(PcInit), 1);
    Start = 1'b0;
    tick();
    halt_after(7);
    chk("t3_ack", 32'(Ack), 1);

    // 4: Halt and Start rise together in RUN -> Halt wins
    launch();
    p0 = pc_cnt;
    push(4, 1'b0);
    repeat (3) tick();
    Halt = 1'b1; Start = 1'b1;
    tick();
    Halt = 1'b0;
    tick(); tick();
    chk("t4_ack", 32'(Ack), 1);
    chk("t4_no_init", 32'(pc_cnt - p0), 0);
    chk("t4_count", 32'(CycleCount), 4);
    Start = 1'b0;
    tick();

    // 5: reset mid-run, Start held through deassert
    launch();
    repeat (9) tick();
    chk("t5_pre_count", 32'(CycleCount), 9);
    Start = 1'b1;
    Reset = 1'b0;
    #1;
    chk("t5_rst_ack", 32'(Ack), 0);
    chk("t5_rst_runen", 32'(RunEn), 0);
    chk("t5_rst_count", 32'(CycleCount), 0);
    tick();
    #2 Reset = 1'b1;
    tick();
    chk("t5_init_after_rst", 32'(PcInit), 1);
    Start = 1'b0;
    tick();
    halt_after(2);

`ifdef START_ACK_WATCHDOG_EN
    // 6: watchdog stops a run that never halts
    launch();
    push(WDOG, 1'b1);
    for (int i = 0; i < 40 && !Ack; i++) tick();
    chk("t6_wdog_ack", 32'(Ack), 1);
    chk("t6_wdog_count", 32'(CycleCount), WDOG);
    chk("t6_wdog_timeout", 32'(Timeout), 1);
    tick();
    // Halt coinciding with the limit: halt wins, edge counts
    launch();
    chk("t6_timeout_clr", 32'(Timeout), 0);
    halt_after(WDOG + 1);
    chk("t6_coincide_to", 32'(Timeout), 0);
`else
    // 6: no watchdog, counter saturates and run continues
    launch();
    push((1 << CNT_W) - 1, 1'b0);
    repeat ((1 << CNT_W) + 6) tick();
    chk("t6_runen", 32'(RunEn), 1);
    chk("t6_sat", 32'(CycleCount), (1 << CNT_W) - 1);
    chk("t6_timeout", 32'(Timeout), 0);
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
`endif

    tick(); tick();
    chk("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/start_ack_ctrl.md
Name: start_ack_ctrl

Overview:
- Responder end of the Start/Ack run handshake between the host (bench or SoC) and the JARchitecture core.
- Sits inside TopLevel between the external Start/Ack pins and the core's program counter and register-file write-enable.
- Sequence: a Start request loads the PC, the core runs until a decoded halt instruction, then Ack is raised.
- Also keeps a saturating run-cycle counter for performance readout.

Parameters:
- PC_W, 10, program counter width.
- START_PC, 0, PC value loaded on each run start (PC_W bits).
- CNT_W, 16, width of the run-cycle counter.
- WDOG_LIMIT, 65535, run-cycle limit that forces termination. Used only when the optional feature is enabled.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  run request from host; level, may be held for multiple cycles.
- Halt  in  1  from the instruction decoder; high while the current instruction is the halt opcode.
- Ack  out  1  done flag to host.
- RunEn  out  1  core advance enable (PC increment/branch, RF and DM writes).
- PcInit  out  1  one-cycle pulse: PC loads StartPc.
- StartPc  out  PC_W  constant START_PC.
- CycleCount  out  CNT_W  RUN cycles of the current or last run.
- Timeout  out  1  last run ended by watchdog. Tied 0 when the feature is compiled out.

Behaviour:
- Reset: while Reset is low, asynchronously set State=IDLE, Ack=0, RunEn=0, PcInit=0, CycleCount=0, Timeout=0, StartPrev=0.
- Start edge: StartRise = Start & ~StartPrev. StartPrev is a register clocked every cycle. Holding Start high produces exactly one run.
- State machine: four states (IDLE, INIT, RUN, DONE). Outputs are Moore-decoded from the registered state:
  - IDLE: all outputs 0. StartRise -> INIT.
  - INIT: exactly one cycle. PcInit=1, RunEn=0, Ack=0. CycleCount cleared to 0, Timeout cleared. Unconditionally -> RUN. Halt is ignored in INIT.
  - RUN: RunEn=1. CycleCount increments by 1 on each RUN clock edge and saturates at 2^CNT_W-1 (no wrap). Halt high at an edge -> DONE; that edge still counts. StartRise in RUN is ignored.
  - DONE: Ack=1, RunEn=0. CycleCount and Timeout hold. StartRise -> INIT, and Ack falls on that edge.
- Latency:
  - Start rise sampled at edge k: PcInit high for cycle k..k+1.
  - RunEn high from edge k+1.
  - Halt sampled at edge m: Ack high from edge m, RunEn low from edge m.
- Simultaneous Halt and StartRise in RUN: Halt wins; StartRise is discarded.
- Reset asserted mid-run: immediate return to IDLE, Ack low. A fresh Start rising edge is required after Reset deasserts. A Start already high at deassert counts as a rise, because StartPrev resets to 0.
- StartPc equals START_PC and is constant.

Optional Feature:
- Macro START_ACK_WATCHDOG_EN.
- Defined: in RUN, if CycleCount == WDOG_LIMIT at an edge and Halt is low -> DONE with Timeout=1. If Halt and the limit coincide, Halt wins and Timeout=0. Timeout holds through DONE; it is cleared in INIT and by reset.
- Undefined: no limit compare. Timeout is tied 0. The run lasts until Halt or Reset.

Decomposition:
- Shared package jar_ctrl_pkg:
  - typedef enum logic [1:0] ctrl_state_t {IDLE, INIT, RUN, DONE}.
  - localparams PC_W_DEF=10, CNT_W_DEF=16.
- Sub-module start_edge_det: StartPrev register plus the rise pulse. Same clock and reset, rise output only.

Test Plan:
- Reset low for 2 cycles, then high. Pulse Start for 1 cycle. Drive Halt after 5 RUN cycles -> PcInit exactly 1 cycle, RunEn high 5 cycles, Ack=1, CycleCount=5, Timeout=0.
- Hold Start high for 20 cycles; Halt at RUN cycle 3 -> exactly one INIT, Ack=1 with Start still high, no second run.
- In DONE, pulse Start again -> Ack falls on the next edge, CycleCount returns to 0, second run counts independently (Halt at 7 -> CycleCount=7).
- In RUN cycle 4, drive Halt and a Start rise in the same cycle -> DONE, CycleCount=4, no INIT follows.
- Assert Reset at RUN cycle 10 -> Ack, RunEn and CycleCount go to 0 immediately. With Start held high through reset deassert -> new INIT on the first edge.
- With START_ACK_WATCHDOG_EN, WDOG_LIMIT=8, Halt never asserted -> DONE at CycleCount=8, Timeout=1, Ack=1. Without the macro -> RunEn stays high and CycleCount saturates at 65535 with CNT_W=16.
